// File: rtl/multdiv_pkg.sv
// Shared constants and FSM encoding for the multiply/divide unit.
package multdiv_pkg;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned DWORD_W  = 64;
  localparam int unsigned ITER_DEF = 32;
  localparam int unsigned CNT_W    = 6;

  typedef enum logic [2:0] {
    IDLE,
    DIV_RUN,
    MULT_RUN,
    FIXUP,
    FINISH
  } state_e;
endpackage

// File: rtl/multdiv_unit_sign_fix.sv
// Two's complement conditional negate: magnitude extraction on the way in,
// sign restoration on the way out.
module sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);
  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit restoring divider with optional radix-2 Booth multiply.
// The multiply path is built only when MULTDIV_MULT_EN is defined.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEF
) (
  input  logic              clk,
  input  logic              Reset_In,
  input  logic              Div_Start,
  input  logic              Mult_Start,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic [WORD_W-1:0] Hi,
  output logic [WORD_W-1:0] Lo,
  output logic              Busy,
  output logic              Done,
  output logic              Zero_Div
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W:0]   rem_q, rem_d;  // guard bit is the Booth accumulator sign
  logic [WORD_W-1:0] quo_q, quo_d, dvs_q, dvs_d;
  logic [WORD_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d, zdiv_q, zdiv_d;
  logic [WORD_W:0]   div_shift, div_diff;

  // Slots: 0 = |A|, 1 = |B|, 2 = signed quotient, 3 = signed remainder.
  logic [WORD_W-1:0] fix_in  [4];
  logic              fix_neg [4];
  logic [WORD_W-1:0] fix_out [4];

  assign fix_in[0]  = A;
  assign fix_in[1]  = B;
  assign fix_in[2]  = quo_q;
  assign fix_in[3]  = rem_q[WORD_W-1:0];
  assign fix_neg[0] = A[WORD_W-1];
  assign fix_neg[1] = B[WORD_W-1];
  assign fix_neg[2] = qneg_q;
  assign fix_neg[3] = rneg_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fix
    sign_fix #(.W(WORD_W)) u_sign_fix (
      .val_i (fix_in[gi]),
      .neg_i (fix_neg[gi]),
      .res_o (fix_out[gi])
    );
  end

  assign div_shift = {rem_q[WORD_W-1:0], quo_q[WORD_W-1]};
  assign div_diff  = div_shift - {1'b0, dvs_q};

`ifdef MULTDIV_MULT_EN
  logic               mul_q, mul_d, booth_q, booth_d;
  logic [WORD_W:0]    booth_acc;
  logic [DWORD_W-1:0] product;

  always_comb begin
    booth_acc = rem_q;
    case ({quo_q[0], booth_q})
      2'b01:   booth_acc = rem_q + {dvs_q[WORD_W-1], dvs_q};
      2'b10:   booth_acc = rem_q - {dvs_q[WORD_W-1], dvs_q};
      default: booth_acc = rem_q;
    endcase
  end
  assign product = {rem_q[WORD_W-1:0], quo_q};
`else
  logic [1:0] unused_bits;
  assign unused_bits = {Mult_Start, rem_q[WORD_W]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zdiv_d  = 1'b0;
`ifdef MULTDIV_MULT_EN
    mul_d   = mul_q;
    booth_d = booth_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Div_Start) begin
          quo_d  = fix_out[0];
          dvs_d  = fix_out[1];
          rem_d  = '0;
          cnt_d  = '0;
          qneg_d = A[WORD_W-1] ^ B[WORD_W-1];
          rneg_d = A[WORD_W-1];
`ifdef MULTDIV_MULT_EN
          mul_d  = 1'b0;
`endif
          if (B == '0) begin
            state_d = FINISH;
            zdiv_d  = 1'b1;
          end else begin
            state_d = DIV_RUN;
          end
        end
`ifdef MULTDIV_MULT_EN
        else if (Mult_Start) begin
          dvs_d   = A;
          quo_d   = B;
          rem_d   = '0;
          cnt_d   = '0;
          booth_d = 1'b0;
          mul_d   = 1'b1;
          state_d = MULT_RUN;
        end
`endif
      end
      DIV_RUN: begin
        // Restore by keeping the shifted value when the trial subtract borrows.
        if (!div_diff[WORD_W]) begin
          rem_d = div_diff;
          quo_d = {quo_q[WORD_W-2:0], 1'b1};
        end else begin
          rem_d = div_shift;
          quo_d = {quo_q[WORD_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = FIXUP;
      end
`ifdef MULTDIV_MULT_EN
      MULT_RUN: begin
        rem_d   = {booth_acc[WORD_W], booth_acc[WORD_W:1]};
        quo_d   = {booth_acc[0], quo_q[WORD_W-1:1]};
        booth_d = quo_q[0];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = FIXUP;
      end
`endif
      FIXUP: begin
`ifdef MULTDIV_MULT_EN
        if (mul_q) begin
          hi_d = product[DWORD_W-1:WORD_W];
          lo_d = product[WORD_W-1:0];
        end else begin
          hi_d = fix_out[3];
          lo_d = fix_out[2];
        end
`else
        hi_d = fix_out[3];
        lo_d = fix_out[2];
`endif
        state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      zdiv_q  <= 1'b0;
`ifdef MULTDIV_MULT_EN
      mul_q   <= 1'b0;
      booth_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zdiv_q  <= zdiv_d;
`ifdef MULTDIV_MULT_EN
      mul_q   <= mul_d;
      booth_q <= booth_d;
`endif
    end
  end

  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign Busy     = (state_q == DIV_RUN) || (state_q == MULT_RUN) || (state_q == FIXUP);
  assign Done     = (state_q == FINISH);
  assign Zero_Div = zdiv_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: arithmetic/timeline reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_multdiv_unit;
  localparam int ITER = 32;
`ifdef MULTDIV_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset_In = 1'b1;
  logic        Div_Start = 1'b0;
  logic        Mult_Start = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] Hi, Lo;
  logic        Busy, Done, Zero_Div;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multdiv_unit #(.ITER(ITER)) dut (
    .clk        (clk),
    .Reset_In   (Reset_In),
    .Div_Start  (Div_Start),
    .Mult_Start (Mult_Start),
    .A          (A),
    .B          (B),
    .Hi         (Hi),
    .Lo         (Lo),
    .Busy       (Busy),
    .Done       (Done),
    .Zero_Div   (Zero_Div)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: signed C-style division and 64-bit product.
  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return 64'h0;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    return p;
  endfunction

  // Timeline model: age counts clock edges since the accepted start (-1 = idle).
  int          age = -1;
  bit          m_zero = 1'b0;
  logic [63:0] pend = 64'h0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  always @(posedge clk or posedge Reset_In) begin
    if (Reset_In) begin
      age    <= -1;
      m_zero <= 1'b0;
      m_hi   <= 32'h0;
      m_lo   <= 32'h0;
    end else if (age < 0) begin
      if (Div_Start) begin
        age    <= 0;
        m_zero <= (B == 32'h0);
        pend   <= div_model(A, B);
      end else if (MULT_EN && Mult_Start) begin
        age    <= 0;
        m_zero <= 1'b0;
        pend   <= mul_model(A, B);
      end
    end else begin
      if (!m_zero && age == ITER) begin
        m_hi <= pend[63:32];
        m_lo <= pend[31:0];
      end
      if ((m_zero && age == 0) || (!m_zero && age == ITER + 1)) age <= -1;
      else age <= age + 1;
    end
  end

  always @(negedge clk) begin
    check("busy", Busy, (age >= 0 && !m_zero && age <= ITER));
    check("done", Done, (age >= 0 && (m_zero ? age == 0 : age == ITER + 1)));
    check("zero_div", Zero_Div, (age >= 0 && m_zero));
    check("hi", Hi, m_hi);
    check("lo", Lo, m_lo);
  end

  // Launch one operation, optionally poke a stray Div_Start while busy, wait for Done.
  task automatic run_op(input bit dv, input bit ml, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output int lat, output int busy_n, output bit zd);
    @(negedge clk);
    A = a; B = b; Div_Start = dv; Mult_Start = ml;
    @(negedge clk);
    Div_Start = 1'b0; Mult_Start = 1'b0;
    lat = 0; busy_n = 0; zd = 1'b0;
    while (!Done && lat < 100) begin
      if (Busy) busy_n++;
      if (lat == poke) begin
        Div_Start = 1'b1; A = 32'd1; B = 32'd1;
      end else begin
        Div_Start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    Div_Start = 1'b0;
    zd = Zero_Div;
    n_vec++;
    if (lat >= 100) begin
      n_err++;
      $display("FAIL done_timeout: waited %0d cycles, required Done within 100", lat);
    end
    $display("op a=%h b=%h div=%0d mult=%0d -> Hi=%h Lo=%h lat=%0d busy=%0d zd=%0d",
             a, b, dv, ml, Hi, Lo, lat, busy_n, zd);
    @(negedge clk);
  endtask

  initial begin
    int lat, busy_n;
    bit zd;

    #7;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_hi", Hi, 0);
    check("rst_lo", Lo, 0);
    @(negedge clk);
    Reset_In = 1'b0;

    run_op(1, 0, 32'd100, 32'd7, 5, lat, busy_n, zd);
    check("lo_100_7", Lo, 32'd14);
    check("hi_100_7", Hi, 32'd2);
    check("done_cycle", lat + 1, 34);
    check("busy_cycles", busy_n, 33);

    run_op(1, 0, 32'hFFFF_FFF9, 32'd2, -1, lat, busy_n, zd);
    check("lo_m7_2", Lo, 32'hFFFF_FFFD);
    check("hi_m7_2", Hi, 32'hFFFF_FFFF);

    run_op(1, 0, 32'd5, 32'd0, -1, lat, busy_n, zd);
    check("zdiv_flag", zd, 1);
    check("zdiv_done_cycle", lat + 1, 1);
    check("zdiv_lo_kept", Lo, 32'hFFFF_FFFD);
    check("zdiv_hi_kept", Hi, 32'hFFFF_FFFF);

    run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, busy_n, zd);
    check("lo_min_m1", Lo, 32'h8000_0000);
    check("hi_min_m1", Hi, 32'h0);
    check("zdiv_min_m1", zd, 0);

    run_op(1, 1, 32'hFFFF_FF9C, 32'd7, -1, lat, busy_n, zd);
    check("lo_both_start", Lo, 32'hFFFF_FFF2);
    check("hi_both_start", Hi, 32'hFFFF_FFFE);

`ifdef MULTDIV_MULT_EN
    run_op(0, 1, 32'hFFFF_FFFD, 32'd4, 3, lat, busy_n, zd);
    check("mul_hi_m3_4", Hi, 32'hFFFF_FFFF);
    check("mul_lo_m3_4", Lo, 32'hFFFF_FFF4);
    check("mul_done_cycle", lat + 1, 34);
    run_op(0, 1, 32'h8000_0000, 32'h8000_0000, -1, lat, busy_n, zd);
    check("mul_hi_min_min", Hi, 32'h4000_0000);
    check("mul_lo_min_min", Lo, 32'h0);
`else
    @(negedge clk);
    A = 32'd9; B = 32'd3; Mult_Start = 1'b1;
    @(negedge clk);
    Mult_Start = 1'b0;
    check("mult_ignored_busy", Busy, 0);
    @(negedge clk);
    check("mult_ignored_done", Done, 0);
    check("mult_ignored_lo", Lo, 32'hFFFF_FFF2);
`endif

    // Reset in the middle of a division.
    @(negedge clk);
    A = 32'd1000; B = 32'd3; Div_Start = 1'b1;
    @(negedge clk);
    Div_Start = 1'b0;
    repeat (10) @(negedge clk);
    #2 Reset_In = 1'b1;
    #1;
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_zdiv", Zero_Div, 0);
    check("midrst_hi", Hi, 0);
    check("midrst_lo", Lo, 0);
    @(negedge clk);
    Reset_In = 1'b0;

    run_op(1, 0, 32'd1000, 32'd3, -1, lat, busy_n, zd);
    check("lo_after_rst", Lo, 32'd333);
    check("hi_after_rst", Hi, 32'd1);

    run_op(1, 0, 32'hFFFF_FC18, 32'hFFFF_FFFD, -1, lat, busy_n, zd);
    check("lo_m1000_m3", Lo, 32'd333);
    check("hi_m1000_m3", Hi, 32'hFFFF_FFFF);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
